// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: simple dual-port synchronous RAM (one write port, one read
// port, one clock) with a sequential hardware clear engine, 1- or 2-cycle
// read latency and optional write-to-read bypass. The array carries no reset
// so it can map onto block RAM; zeroing is done by sweeping every location.
module ram_sdp_clr #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid
);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    // Where the first-stage read result comes from.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_MEM,
        SRC_BYP
    } rd_src_t;

    // One extra bit so DEPTH = 2^ADDR_W is representable in range checks.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              port_wr;
    logic              rd_launch;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] rd_idx;

    logic [DATA_W-1:0] mem_rd_q;

    logic              s1_valid_q, s1_valid_d;
    rd_src_t           s1_src_q, s1_src_d;
    logic [DATA_W-1:0] s1_byp_q, s1_byp_d;
    logic [DATA_W-1:0] s1_data;

    assign wr_in_range = ({1'b0, write_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, read_addr} < DEPTH_X);
    assign busy        = (state_q == ST_CLEAR);

    // Next-state logic: the sweep owns the write port while clearing; in RUN a
    // clear request wins over a same-cycle write, but a read still launches.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = write_addr;
        mem_wdata  = write_data;
        port_wr    = 1'b0;
        rd_launch  = 1'b0;
        rd_idx     = rd_in_range ? read_addr : '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = '0;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_RUN: begin
                rd_launch = read_en;
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (write_en && wr_in_range) begin
                    mem_we  = 1'b1;
                    port_wr = 1'b1;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // State and sweep-address registers; reset restarts the sweep at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Array write port (no reset so the array stays block-RAM friendly).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered array read; sees pre-write contents on a same-address write.
    always_ff @(posedge clk) begin
        if (rd_launch) begin
            mem_rd_q <= mem[rd_idx];
        end
    end

    // Decide the first-stage source: out-of-range reads return zero, and a
    // same-address write can be forwarded when bypass is enabled.
    always_comb begin
        s1_valid_d = rd_launch;
        s1_byp_d   = write_data;
        s1_src_d   = SRC_ZERO;
        if (rd_launch && rd_in_range) begin
            if ((BYPASS != 0) && port_wr && (write_addr == read_addr)) begin
                s1_src_d = SRC_BYP;
            end else begin
                s1_src_d = SRC_MEM;
            end
        end
    end

    // First read stage control registers; zeroed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= SRC_ZERO;
            s1_byp_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_src_q   <= s1_src_d;
            s1_byp_q   <= s1_byp_d;
        end
    end

    // Select first-stage data; anything without a result reads as zero.
    always_comb begin
        s1_data = '0;
        case (s1_src_q)
            SRC_MEM: s1_data = mem_rd_q;
            SRC_BYP: s1_data = s1_byp_q;
            default: s1_data = '0;
        endcase
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid_q, s2_valid_d;
            logic [DATA_W-1:0] s2_data_q, s2_data_d;

            // Second stage simply carries valid and data together.
            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s1_data;
            end

            // Extra output register stage for the two-cycle latency build.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign read_valid = s2_valid_q;
            assign read_data  = s2_data_q;
        end else begin : g_lat1
            assign read_valid = s1_valid_q;
            assign read_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_clr.sv
// tb_ram_sdp_clr: drives two builds of ram_sdp_clr with identical stimulus
// (A: DEPTH 256, 1-cycle latency, bypass; B: DEPTH 200, 2-cycle latency, no
// bypass) and checks both against a word-level reference model every cycle.
module tb_ram_sdp_clr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clrReq = 1'b0;
    logic       writeEn = 1'b0;
    logic [7:0] writeAddr = '0;
    logic [5:0] writeData = '0;
    logic       readEn = 1'b0;
    logic [7:0] readAddr = '0;

    logic       busyA, busyB;
    logic [5:0] readDataA, readDataB;
    logic       readValidA, readValidB;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       v;
        logic [5:0] d;
    } res_t;

    logic [5:0] mdlMem [2][256];
    int         busyLeft [2];
    res_t       expRes [2];
    res_t       pipeA [$];
    res_t       pipeB [$];

    ram_sdp_clr #(.DATA_W(6), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .BYPASS(1)) dutA (
        .clk(clk), .rst(rst), .clr_req(clrReq), .busy(busyA),
        .write_en(writeEn), .write_addr(writeAddr), .write_data(writeData),
        .read_en(readEn), .read_addr(readAddr),
        .read_data(readDataA), .read_valid(readValidA)
    );

    ram_sdp_clr #(.DATA_W(6), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .BYPASS(0)) dutB (
        .clk(clk), .rst(rst), .clr_req(clrReq), .busy(busyB),
        .write_en(writeEn), .write_addr(writeAddr), .write_data(writeData),
        .read_en(readEn), .read_addr(readAddr),
        .read_data(readDataB), .read_valid(readValidB)
    );

    always #5 clk = ~clk;

    // Global time limit so the run can never hang.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int depthOf(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic bit bypOf(input int k);
        return (k == 0);
    endfunction

    // Reference model: one call per clock edge using the inputs in force.
    task automatic modelStep(input int k);
        res_t res;
        res = '0;
        if (rst) begin
            busyLeft[k] = depthOf(k);
            for (int i = 0; i < 256; i++) mdlMem[k][i] = '0;
            if (k == 0) pipeA.delete(); else pipeB.delete();
            for (int i = 0; i < latOf(k) - 1; i++) begin
                if (k == 0) pipeA.push_back('0); else pipeB.push_back('0);
            end
            expRes[k] = '0;
            return;
        end
        if (busyLeft[k] > 0) begin
            busyLeft[k]--;
        end else begin
            if (readEn) begin
                res.v = 1'b1;
                if (int'(readAddr) < depthOf(k)) begin
                    if (bypOf(k) && writeEn && !clrReq && writeAddr == readAddr)
                        res.d = writeData;
                    else
                        res.d = mdlMem[k][readAddr];
                end
            end
            if (clrReq) begin
                for (int i = 0; i < 256; i++) mdlMem[k][i] = '0;
                busyLeft[k] = depthOf(k);
            end else if (writeEn && int'(writeAddr) < depthOf(k)) begin
                mdlMem[k][writeAddr] = writeData;
            end
        end
        if (k == 0) begin
            pipeA.push_back(res);
            expRes[0] = pipeA.pop_front();
        end else begin
            pipeB.push_back(res);
            expRes[1] = pipeB.pop_front();
        end
    endtask

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("A.busy",  {7'd0, busyA},      {7'd0, (busyLeft[0] > 0)});
        checkVal("A.valid", {7'd0, readValidA}, {7'd0, expRes[0].v});
        checkVal("A.data",  {2'd0, readDataA},  {2'd0, expRes[0].d});
        checkVal("B.busy",  {7'd0, busyB},      {7'd0, (busyLeft[1] > 0)});
        checkVal("B.valid", {7'd0, readValidB}, {7'd0, expRes[1].v});
        checkVal("B.data",  {2'd0, readDataB},  {2'd0, expRes[1].d});
    endtask

    task automatic applyStimulus(input logic r, input logic cr, input logic we,
                                 input logic [7:0] wa, input logic [5:0] wd,
                                 input logic re, input logic [7:0] ra);
        rst = r; clrReq = cr; writeEn = we; writeAddr = wa; writeData = wd;
        readEn = re; readAddr = ra;
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [5:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, a, d, 1'b0, 8'd0);
    endtask

    task automatic rd(input logic [7:0] a);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 1'b1, a);
    endtask

    task automatic noisy();
        applyStimulus(1'b0, 1'b0, 1'($urandom), 8'($urandom_range(0, 255)),
                      6'($urandom), 1'($urandom), 8'($urandom_range(0, 255)));
    endtask

    // Count edges until each build first reports busy low (0 = never, bounded).
    task automatic waitIdle(input bit noise, output int nA, output int nB);
        nA = 0;
        nB = 0;
        for (int n = 1; n <= 600; n++) begin
            if (noise) noisy(); else idle();
            if (!busyA && nA == 0) nA = n;
            if (!busyB && nB == 0) nB = n;
            if (nA != 0 && nB != 0) break;
        end
    endtask

    initial begin
        int nA, nB;

        // Post-reset sweep length and zeroed contents.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
        checkVal("reset.A.busy", {7'd0, busyA}, 8'd1);
        checkVal("reset.A.valid", {7'd0, readValidA}, 8'd0);
        waitIdle(1'b0, nA, nB);
        checkVal("sweep.A.len", 8'(nA), 8'(256 & 8'hFF));
        checkVal("sweep.A.len.hi", 8'(nA >> 8), 8'd1);
        checkVal("sweep.B.len", 8'(nA == 256 ? nB : 0), 8'd200);
        rd(8'd0);
        rd(8'd128);
        rd(8'd255);
        checkVal("t1.A.valid", {7'd0, readValidA}, 8'd1);
        checkVal("t1.A.data", {2'd0, readDataA}, 8'd0);
        idle();
        idle();

        // Write then read at both latencies, back to back.
        wr(8'h10, 6'h2A);
        wr(8'hFF, 6'h15);
        rd(8'h10);
        checkVal("t2.A.lat1", {2'd0, readDataA}, 8'h2A);
        checkVal("t2.B.notyet", {7'd0, readValidB}, 8'd0);
        rd(8'hFF);
        checkVal("t2.A.b2b", {2'd0, readDataA}, 8'h15);
        checkVal("t2.B.lat2", {2'd0, readDataB}, 8'h2A);
        idle();
        checkVal("t2.A.none", {7'd0, readValidA}, 8'd0);
        checkVal("t2.B.oor.valid", {7'd0, readValidB}, 8'd1);
        checkVal("t2.B.oor.data", {2'd0, readDataB}, 8'd0);
        idle();

        // Same-cycle write and read of one address.
        wr(8'h20, 6'h11);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20, 6'h3C, 1'b1, 8'h20);
        checkVal("t3.A.bypass", {2'd0, readDataA}, 8'h3C);
        rd(8'h20);
        checkVal("t3.A.after", {2'd0, readDataA}, 8'h3C);
        checkVal("t3.B.old", {2'd0, readDataB}, 8'h11);
        idle();
        checkVal("t3.B.after", {2'd0, readDataB}, 8'h3C);

        // Run-time clear with a colliding write and read.
        for (int i = 0; i < 256; i++) wr(8'(i), 6'(i));
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h05, 6'h3F, 1'b1, 8'h07);
        checkVal("t4.A.preclear", {2'd0, readDataA}, 8'h07);
        checkVal("t4.A.busy", {7'd0, busyA}, 8'd1);
        waitIdle(1'b1, nA, nB);
        checkVal("t4.A.len", 8'(nA - 200), 8'd56);
        checkVal("t4.B.len", 8'(nB), 8'd200);
        rd(8'h05);
        checkVal("t4.A.cleared5", {2'd0, readDataA}, 8'd0);
        rd(8'h07);
        checkVal("t4.A.cleared7", {2'd0, readDataA}, 8'd0);
        idle();
        idle();

        // Clear request mid-sweep is ignored.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
        for (int i = 0; i < 99; i++) noisy();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
        waitIdle(1'b1, nA, nB);
        checkVal("t5.clr.A.rest", 8'(nA), 8'd156);
        checkVal("t5.clr.B.rest", 8'(nB), 8'd100);

        // Reset mid-sweep restarts the full sweep.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
        for (int i = 0; i < 99; i++) noisy();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 6'd0, 1'b0, 8'd0);
        waitIdle(1'b0, nA, nB);
        checkVal("t5.rst.A.len", 8'(nA - 200), 8'd56);
        checkVal("t5.rst.B.len", 8'(nB), 8'd200);

        // Top-of-range behaviour on the 200-word build.
        wr(8'd200, 6'h3F);
        rd(8'd200);
        idle();
        checkVal("t5.B.oor.valid", {7'd0, readValidB}, 8'd1);
        checkVal("t5.B.oor.data", {2'd0, readDataB}, 8'd0);
        rd(8'd199);
        idle();
        checkVal("t5.B.last", {2'd0, readDataB}, 8'd0);
        checkVal("t5.B.last.valid", {7'd0, readValidB}, 8'd1);

        // Randomized traffic with occasional clears and collisions.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] wa, ra;
            wa = 8'($urandom_range(0, 255));
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 255));
            applyStimulus(1'b0, ($urandom_range(0, 149) == 0), 1'($urandom),
                          wa, 6'($urandom), ($urandom_range(0, 9) < 6), ra);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
